// File: rtl/mem_arb_pkg.sv
// Shared definitions for the icache/dcache memory arbiter: FSM encoding,
// client identifiers and default bus widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 128;

  localparam logic CLIENT_I = 1'b0;
  localparam logic CLIENT_D = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SERVE_I = 3'd1,
    ST_SERVE_D = 3'd2,
    ST_RESP_I  = 3'd3,
    ST_RESP_D  = 3'd4
  } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: on a tie the client that did not win last
// time is chosen; with a single request that requester wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic winner
);

  always_comb begin
    winner = CLIENT_I;
    if (req_i && req_d) begin
      winner = ~last_grant;
    end else if (req_d) begin
      winner = CLIENT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache and dcache block requests onto one busywait-style memory
// port, holding each granted request stable until memory completes.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              seen_busy_q, seen_busy_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic req_i, req_d, winner, serving;

  assign req_i = I_READ;
  assign req_d = D_READ | D_WRITE;

  rr_pick2 u_pick (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_grant (last_grant_q),
    .winner     (winner)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    seen_busy_d  = seen_busy_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        seen_busy_d = 1'b0;
        if (req_i || req_d) begin
          // Only a genuine tie moves the round-robin pointer.
          if (req_i && req_d) last_grant_d = winner;
          if (winner == CLIENT_I) begin
            state_d = ST_SERVE_I;
            write_d = 1'b0;
            addr_d  = I_ADDRESS;
            wdata_d = '0;
          end else begin
            state_d = ST_SERVE_D;
            write_d = D_WRITE;
            addr_d  = D_ADDRESS;
            wdata_d = D_WRITE ? D_WRITEDATA : '0;
          end
        end
      end
      ST_SERVE_I, ST_SERVE_D: begin
        // Busy must be observed before its falling edge means completion.
        if (MEM_BUSYWAIT) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          seen_busy_d = 1'b0;
          if (state_q == ST_SERVE_I) begin
            state_d   = ST_RESP_I;
            i_rdata_d = MEM_READDATA;
          end else begin
            state_d = ST_RESP_D;
            if (!write_q) d_rdata_d = MEM_READDATA;
          end
        end
      end
      ST_RESP_I, ST_RESP_D: state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      last_grant_q <= CLIENT_D;
      seen_busy_q  <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      seen_busy_q  <= seen_busy_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign serving       = (state_q == ST_SERVE_I) || (state_q == ST_SERVE_D);
  assign MEM_READ      = serving & ~write_q;
  assign MEM_WRITE     = serving & write_q;
  assign MEM_ADDRESS   = serving ? addr_q : '0;
  assign MEM_WRITEDATA = (serving && write_q) ? wdata_q : '0;

  assign I_READDATA = i_rdata_q;
  assign D_READDATA = d_rdata_q;
  assign I_BUSYWAIT = req_i & (state_q != ST_RESP_I);
  assign D_BUSYWAIT = req_d & (state_q != ST_RESP_D);

endmodule
